myproject_mul_share_sched: RTL
==============================

# myproject_mul_share_sched

Round-robin scheduler that time-shares a single 16-bit signed × 10-bit unsigned multiplier cell among N_REQ requesters in the HLS4ML gluon-tagger datapath. Each requester presents one operand pair under valid/ready. The block grants one requester per cycle, runs the product through a two-stage registered pipeline, and returns a 26-bit signed result tagged with the requester index under valid/ready backpressure. It sits between the layer-compute engines and the shared DSP multiplier.

## Interface
- N_REQ, 4: number of requesters, 2..8.
- ID_W, 2: requester-index width, equal to clog2(N_REQ).
- ap_clk  in  1  single clock; all state is updated on the rising edge.
- ap_rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  N_REQ  per-requester operand valid.
- req_ready  out  N_REQ  per-requester accept; at most one bit is high in any cycle.
- req_a  in  16*N_REQ  signed operand A; requester i occupies bits [16i+15:16i].
- req_b  in  10*N_REQ  unsigned operand B; requester i occupies bits [10i+9:10i].
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accept.
- res_data  out  26  signed product.
- res_id  out  ID_W  index of the requester that produced res_data.
- idle  out  1  high when both pipeline stages are empty.
- op_count  out  32  count of accepted operations; wraps modulo 2^32.

## Operation
- Pipeline has two stages:
  - S1 holds the operand register: s1_valid, a, b, id.
  - S2 holds the result register: s2_valid, p, id. res_* outputs are driven directly from S2.
- Advance rules:
  - adv2 = !s2_valid | res_ready.
  - adv1 = !s1_valid | adv2.
- Grant is combinational:
  - Search req_valid starting at rr_ptr, wrapping modulo N_REQ.
  - The first set bit wins.
  - req_ready[i] = grant[i] & adv1.
- Accept occurs when req_valid[i] & req_ready[i]:
  - S1 loads that requester's operands and index.
  - rr_ptr <= (i+1) mod N_REQ; wrap-around at N_REQ-1 goes to 0.
  - op_count increments by 1.
- With no accept, rr_ptr holds its value.
- When adv1 is high and nothing is accepted, s1_valid clears.
- When adv2 is high, S2 loads p = signed(a) * signed({1'b0,b}) from S1 through the multiplier cell, together with S1's id and s1_valid.
- The product is exact in 26 bits: no rounding, saturation or overflow is possible.
- Stalls: while res_valid & !res_ready, S2 holds. If S1 is also full, all req_ready bits are 0.
- Requesters must hold req_valid and their operands stable until accepted. The block never drops or duplicates an operation.
- idle = !s1_valid & !s2_valid.

## Timing
- Reset values: req_ready=0, res_valid=0, res_data=0, res_id=0, idle=1, op_count=0, rr_ptr=0, and all stage registers 0.
- Asserting ap_rst_n low mid-operation discards all in-flight operations immediately. No result for them is ever emitted.
- Latency: an accept in cycle C produces res_valid high in cycle C+2 when there is no backpressure.
- Throughput: one operation per cycle sustained while res_ready=1.
- Full pipeline with res_ready low: req_ready is 0 that cycle.
- In the cycle res_ready rises, both stages advance, so a new accept in that same cycle is allowed.
- Simultaneous requests: exactly one grant per cycle. With all N_REQ requesters valid continuously, grants rotate 0,1,…,N_REQ-1,0.
- Results leave in acceptance order.

## Structure
- A shared package/header `myproject_mul_share_pkg` holds:
  - the operand widths 16 and 10 and the result width 26;
  - the default N_REQ;
  - the ID_W derivation.
- Sub-module `myproject_rr_arbiter`:
  - parameter N;
  - inputs req vector, ptr and enable;
  - outputs one-hot grant and encoded index.
- The multiplier is the team's existing 16s×10ns→26 multiplier cell, instantiated once between S1 and S2.

## Test plan
- Single requester 2: a=-32768, b=1023, res_ready=1. Expect res_valid 2 cycles after accept, res_data=-33521664, res_id=2, op_count=1, and idle returns high.
- All four requesters valid continuously with distinct operands: a=100+i, b=3. Expect grants in order 0,1,2,3,0,…, results (100+i)*3 with matching res_id, one result per cycle.
- Backpressure: hold res_ready=0 for 5 cycles with requesters 0 and 1 valid. Expect exactly 2 accepts, res_* stable throughout, req_ready=0 thereafter; on release, results drain in order with no loss.
- Pointer wrap: only requester 3 valid, then 0 and 3 valid together. Expect requester 0 granted first, since rr_ptr=0 after wrap.
- Assert reset with both stages full. Expect res_valid=0 and idle=1 immediately; after release the in-flight results are never emitted and op_count=0.
- Operand extremes: a=32767, b=1023 gives 33520641. a=-1, b=0 gives 0.

Source files
------------

// File: rtl/myproject_mul_share_pkg.sv
// Shared widths and helpers for the time-shared multiplier scheduler.
package myproject_mul_share_pkg;

  localparam int unsigned A_W       = 16;
  localparam int unsigned B_W       = 10;
  localparam int unsigned P_W       = 26;
  localparam int unsigned N_REQ_DEF = 4;

  // Requester-index width; a single requester still needs one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Operand pair carried from the grant mux into stage 1.
  typedef struct packed {
    logic signed [A_W-1:0] a;
    logic        [B_W-1:0] b;
  } op_t;

endpackage

// File: rtl/myproject_mul_16s_10ns_26.sv
// Shared DSP cell: 16-bit signed times 10-bit unsigned, exact 26-bit signed product.
module myproject_mul_16s_10ns_26
  import myproject_mul_share_pkg::*;
(
  input  logic signed [A_W-1:0] a,
  input  logic        [B_W-1:0] b,
  output logic signed [P_W-1:0] p
);

  logic signed [B_W:0] b_s;

  // Zero-extend b so the signed multiply treats it as non-negative.
  assign b_s = $signed({1'b0, b});
  assign p   = P_W'(a) * P_W'(b_s);

endmodule

// File: rtl/myproject_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr wins, wrapping modulo N.
module myproject_rr_arbiter #(
  parameter int unsigned N = 4,
  parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         en,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx
);

  logic        found;
  int unsigned j;

  // Rotating priority search starting at ptr.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(ptr) + k) % N;
      if (en && !found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = W'(j);
      end
    end
  end

endmodule

// File: rtl/myproject_mul_share_sched.sv
// Round-robin scheduler feeding one shared multiplier through a two-stage pipeline.
module myproject_mul_share_sched
  import myproject_mul_share_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned ID_W  = id_width(N_REQ)
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [A_W*N_REQ-1:0]    req_a,
  input  logic [B_W*N_REQ-1:0]    req_b,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic signed [P_W-1:0]   res_data,
  output logic [ID_W-1:0]         res_id,
  output logic                    idle,
  output logic [31:0]             op_count
);

  logic                   adv1;
  logic                   adv2;
  logic                   accept;
  logic [N_REQ-1:0]       grant;
  logic [ID_W-1:0]        gnt_idx;
  logic [ID_W-1:0]        rr_ptr;
  op_t                    sel_op;

  logic                   s1_valid;
  op_t                    s1_op;
  logic [ID_W-1:0]        s1_id;

  logic                   s2_valid;
  logic signed [P_W-1:0]  s2_p;
  logic [ID_W-1:0]        s2_id;

  logic signed [P_W-1:0]  prod;

  assign adv2 = ~s2_valid | res_ready;
  assign adv1 = ~s1_valid | adv2;

  // Grant only while stage 1 can take a new operand and reset is released.
  myproject_rr_arbiter #(
    .N (N_REQ),
    .W (ID_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .en    (adv1 & ap_rst_n),
    .grant (grant),
    .idx   (gnt_idx)
  );

  assign req_ready = grant;
  assign accept    = |(req_valid & grant);

  // Select the granted requester's operand pair.
  always_comb begin
    sel_op   = '0;
    sel_op.a = req_a[32'(gnt_idx)*A_W +: A_W];
    sel_op.b = req_b[32'(gnt_idx)*B_W +: B_W];
  end

  // Round-robin pointer moves just past the last accepted requester.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (32'(gnt_idx) == N_REQ - 1) ? '0 : ID_W'(gnt_idx + 1'b1);
    end
  end

  // Accepted-operation counter, wraps naturally.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      op_count <= '0;
    end else if (accept) begin
      op_count <= op_count + 32'd1;
    end
  end

  // Stage 1: operand register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_id    <= '0;
    end else if (adv1) begin
      s1_valid <= accept;
      if (accept) begin
        s1_op <= sel_op;
        s1_id <= gnt_idx;
      end
    end
  end

  myproject_mul_16s_10ns_26 u_mul (
    .a (s1_op.a),
    .b (s1_op.b),
    .p (prod)
  );

  // Stage 2: result register, drives the result port directly.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s2_valid <= 1'b0;
      s2_p     <= '0;
      s2_id    <= '0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      s2_p     <= prod;
      s2_id    <= s1_id;
    end
  end

  assign res_valid = s2_valid;
  assign res_data  = s2_p;
  assign res_id    = s2_id;
  assign idle      = ~s1_valid & ~s2_valid;

endmodule
